// File: rtl/seg7_scan_ctrl_pkg.sv
// rtl/seg7_scan_ctrl_pkg.sv - shared types and active-low segment patterns for the 7-segment scanner
// Patterns are {g,f,e,d,c,b,a}, 0 = segment lit.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - producer-side value/update bus and display pin bundle
// master = BCD producer / board model, slave = scan controller.
interface seg7_scan_ctrl_if #(
  parameter int N_DIG = 4
);
  logic [4*N_DIG-1:0] bcd_in;
  logic [N_DIG-1:0]   dp_in;
  logic               load;
  logic               lz_en;
  logic [N_DIG-1:0]   an;
  logic [6:0]         seg;
  logic               dp;
  logic               frame_done;

  modport master (
    output bcd_in, dp_in, load, lz_en,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  bcd_in, dp_in, load, lz_en,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl_bcd_to_seg7.sv
// rtl/seg7_scan_ctrl_bcd_to_seg7.sv - combinational BCD to active-low 7-segment decoder
// Non-decimal codes render as a dash; blank forces every segment off.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
    if (blank_i) begin
      seg_o = SEG_OFF;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan scheduler with dead-time and frame-synchronous updates
// The state register lags the slot counter by one cycle; pins lag the state by one more.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic              clk,
  input  logic              reset,
  seg7_scan_ctrl_if.slave   bus
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam int IW = $clog2(N_DIG);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] CNT_SHOW  = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               lz_q, lz_d;
  logic [4*N_DIG-1:0] disp_q, disp_d, shad_q, shad_d;
  logic [N_DIG-1:0]   ddp_q, ddp_d, sdp_q, sdp_d;
  logic               pend_q, pend_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               fd_q, fd_d;

  logic               boundary;
  logic               upper_zero;
  logic               cur_blank;
  logic [3:0]         cur_bcd;
  logic [6:0]         dec_seg;

  bcd_to_seg7 u_dec (
    .bcd_i   (cur_bcd),
    .blank_i (cur_blank),
    .seg_o   (dec_seg)
  );

  always_comb begin
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    state_d  = state_q;
    idx_d    = idx_q;
    lz_d     = lz_q;
    boundary = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == CNT_SHOW) begin
          state_d = SHOW;
          lz_d    = bus.lz_en;
        end
      end
      SHOW: begin
        // Counter reading 0 here means it wrapped on the previous edge.
        if (cnt_q == '0) begin
          state_d  = BLANK;
          idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          boundary = (idx_q == IDX_LAST);
        end
      end
      default: state_d = BLANK;
    endcase
  end

  always_comb begin
    disp_d = disp_q;
    ddp_d  = ddp_q;
    shad_d = shad_q;
    sdp_d  = sdp_q;
    pend_d = pend_q;
    if (bus.load) begin
      shad_d = bus.bcd_in;
      sdp_d  = bus.dp_in;
      pend_d = 1'b1;
    end
    // A load landing on the boundary bypasses the shadow straight to the display.
    if (boundary) begin
      if (bus.load) begin
        disp_d = bus.bcd_in;
        ddp_d  = bus.dp_in;
        pend_d = 1'b0;
      end else if (pend_q) begin
        disp_d = shad_q;
        ddp_d  = sdp_q;
        pend_d = 1'b0;
      end
    end
  end

  always_comb begin
    cur_bcd    = disp_q[4*idx_q +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < N_DIG; j++) begin
      if (j >= int'(idx_q) && disp_q[4*j +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end
    cur_blank = lz_q && (idx_q != '0) && upper_zero;

    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    fd_d  = boundary;
    if (state_q == SHOW) begin
      an_d[idx_q] = 1'b0;
      seg_d       = dec_seg;
      dp_d        = ~ddp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      state_q <= BLANK;
      idx_q   <= '0;
      lz_q    <= 1'b0;
      disp_q  <= '0;
      ddp_q   <= '0;
      shad_q  <= '0;
      sdp_q   <= '0;
      pend_q  <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      lz_q    <= lz_d;
      disp_q  <= disp_d;
      ddp_q   <= ddp_d;
      shad_q  <= shad_d;
      sdp_q   <= sdp_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;

endmodule
